// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU operand dispatcher.
//   - XLEN / opcode / register-index / shift-amount widths
//   - ALU opcode constants and the legal-opcode / shift-opcode helpers
//   - alu_disp_state_t: dispatcher FSM states
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int OP_W    = 5;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_SLT  = 5'd2;
  localparam logic [OP_W-1:0] OP_SLTU = 5'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd4;
  localparam logic [OP_W-1:0] OP_OR   = 5'd6;
  localparam logic [OP_W-1:0] OP_AND  = 5'd7;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd8;
  localparam logic [OP_W-1:0] OP_SRL  = 5'd12;
  localparam logic [OP_W-1:0] OP_SRA  = 5'd13;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } alu_disp_state_t;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR,
      OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_fmt.sv
// alu_operand_fmt: combinational operand-2 formatter.
//   op      in  5  : ALU opcode
//   rs2     in 32  : register operand 2
//   imm     in 32  : sign-extended immediate
//   use_imm in  1  : select imm instead of rs2
//   dat2    out 32 : formatted operand 2 (shift amount masked for shifts)
module alu_operand_fmt
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  output logic [XLEN-1:0] dat2
);

  // Only the low SHAMT_W bits are a shift amount; SRAI carries its
  // arithmetic-select bit at imm[10], which must not reach the shifter.
  function automatic logic [XLEN-1:0] mask_shamt(input logic [XLEN-1:0] v);
    return {{(XLEN-SHAMT_W){1'b0}}, v[SHAMT_W-1:0]};
  endfunction

  logic [XLEN-1:0] src2;

  always_comb begin
    src2 = use_imm ? imm : rs2;
    dat2 = is_shift_op(op) ? mask_shamt(src2) : src2;
  end

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: producer side of the ALU functional-unit interface.
// Accepts one decoded op per issue handshake, presents formatted operands
// to the registered ALU units for one dat_ready cycle, captures ALU_result
// the cycle after, and returns it on the wb valid/ready handshake.
// Ports:
//   soc_clk, reset_n (sync, active-low)
//   issue_valid/issue_ready, issue_op, issue_rs1, issue_rs2, issue_imm,
//   issue_use_imm, issue_rd                 : decode side
//   dat_ready, ALU_dat1, ALU_dat2, Instruction_to_ALU, ALU_result : unit bank
//   wb_valid/wb_ready, wb_data, wb_rd       : writeback side
//   wb_illegal                              : only with ALU_DISPATCH_ILLEGAL_OP_EN
// Macro ALU_DISPATCH_ILLEGAL_OP_EN: flags opcodes outside the legal set,
// suppresses their dat_ready and returns zero data for them.
module alu_dispatch
  import alu_pkg::*;
(
  input  logic             soc_clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [XLEN-1:0]  issue_rs1,
  input  logic [XLEN-1:0]  issue_rs2,
  input  logic [XLEN-1:0]  issue_imm,
  input  logic             issue_use_imm,
  input  logic [REG_W-1:0] issue_rd,
  output logic             dat_ready,
  output logic [XLEN-1:0]  ALU_dat1,
  output logic [XLEN-1:0]  ALU_dat2,
  output logic [OP_W-1:0]  Instruction_to_ALU,
  input  logic [XLEN-1:0]  ALU_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [XLEN-1:0]  wb_data,
`ifdef ALU_DISPATCH_ILLEGAL_OP_EN
  output logic             wb_illegal,
`endif
  output logic [REG_W-1:0] wb_rd
);

  alu_disp_state_t state, state_nxt;
  logic            accept;
  logic [XLEN-1:0] dat2_fmt;
  logic [REG_W-1:0] rd_p0;
  logic            illegal_p0;

  alu_operand_fmt u_fmt (
    .op      (issue_op),
    .rs2     (issue_rs2),
    .imm     (issue_imm),
    .use_imm (issue_use_imm),
    .dat2    (dat2_fmt)
  );

  always_ff @(posedge soc_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (wb_ready) state_nxt = accept ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_ready = (state == IDLE) || ((state == RESP) && wb_ready);
    accept      = issue_valid && issue_ready;
    dat_ready   = (state == ISSUE) && !illegal_p0;
    wb_valid    = (state == RESP);
  end

`ifdef ALU_DISPATCH_ILLEGAL_OP_EN
  always_ff @(posedge soc_clk) begin
    if (!reset_n)    illegal_p0 <= 1'b0;
    else if (accept) illegal_p0 <= !is_legal_op(issue_op);
  end
  assign wb_illegal = wb_valid && illegal_p0;
`else
  assign illegal_p0 = 1'b0;
`endif

  always_ff @(posedge soc_clk) begin
    if (!reset_n) begin
      ALU_dat1           <= '0;
      ALU_dat2           <= '0;
      Instruction_to_ALU <= '0;
      rd_p0              <= '0;
      wb_data            <= '0;
      wb_rd              <= '0;
    end else begin
      // accept: operands stay put until the next accept
      if (accept) begin
        ALU_dat1           <= issue_rs1;
        ALU_dat2           <= dat2_fmt;
        Instruction_to_ALU <= issue_op;
        rd_p0              <= issue_rd;
      end
      // capture: unit result is only valid the cycle after dat_ready
      if (state == CAPTURE) begin
        wb_data <= illegal_p0 ? '0 : ALU_result;
        wb_rd   <= rd_p0;
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;
  import alu_pkg::*;

  logic        soc_clk = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_op;
  logic [31:0] issue_rs1, issue_rs2, issue_imm;
  logic        issue_use_imm;
  logic [4:0]  issue_rd;
  logic        dat_ready;
  logic [31:0] ALU_dat1, ALU_dat2;
  logic [4:0]  Instruction_to_ALU;
  logic [31:0] ALU_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
`ifdef ALU_DISPATCH_ILLEGAL_OP_EN
  logic        wb_illegal;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 soc_clk = ~soc_clk;

  alu_dispatch dut (
    .soc_clk            (soc_clk),
    .reset_n            (reset_n),
    .issue_valid        (issue_valid),
    .issue_ready        (issue_ready),
    .issue_op           (issue_op),
    .issue_rs1          (issue_rs1),
    .issue_rs2          (issue_rs2),
    .issue_imm          (issue_imm),
    .issue_use_imm      (issue_use_imm),
    .issue_rd           (issue_rd),
    .dat_ready          (dat_ready),
    .ALU_dat1           (ALU_dat1),
    .ALU_dat2           (ALU_dat2),
    .Instruction_to_ALU (Instruction_to_ALU),
    .ALU_result         (ALU_result),
    .wb_valid           (wb_valid),
    .wb_ready           (wb_ready),
    .wb_data            (wb_data),
`ifdef ALU_DISPATCH_ILLEGAL_OP_EN
    .wb_illegal         (wb_illegal),
`endif
    .wb_rd              (wb_rd)
  );

  // Registered ALU unit bank: result appears only in the cycle after
  // dat_ready; any other cycle shows a junk pattern. Shifts use the full
  // operand so an unmasked shift amount shows up in the result.
  function automatic logic [31:0] unit_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'd0, a < b};
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SLL:  return a << b;
      OP_SRL:  return a >> b;
      OP_SRA:  return $unsigned($signed(a) >>> b);
      default: return 32'h0BAD_0BAD;
    endcase
  endfunction

  logic        unit_vld = 1'b0;
  logic [31:0] unit_res = 32'd0;
  always @(posedge soc_clk) begin
    unit_vld <= dat_ready;
    if (dat_ready) unit_res <= unit_fn(Instruction_to_ALU, ALU_dat1, ALU_dat2);
  end
  assign ALU_result = unit_vld ? unit_res : 32'hA5A5_5A5A;

  // Reference model: what writeback should see, from the issued operation.
  function automatic logic ref_is_shift(input logic [4:0] op);
    return (op == 5'd8) || (op == 5'd12) || (op == 5'd13);
  endfunction

  function automatic logic [31:0] ref_dat2(input logic [4:0] op, input logic [31:0] src2);
    return ref_is_shift(op) ? (src2 % 32) : src2;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] src2);
    int unsigned sh;
    longint sa, sb;
    sh = src2 % 32;
    sa = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
    sb = src2[31] ? longint'(src2) - 64'sd4294967296 : longint'(src2);
    case (op)
      OP_ADD:  return 32'(a + src2);
      OP_SUB:  return 32'(a - src2);
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < src2) ? 32'd1 : 32'd0;
      OP_XOR:  return a ^ src2;
      OP_OR:   return a | src2;
      OP_AND:  return a & src2;
      OP_SLL:  return 32'(a * (64'd1 << sh));
      OP_SRL:  return a / (32'd1 << sh);
      OP_SRA:  return a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
      default: return 32'd0;
    endcase
  endfunction

  logic [4:0] legal_ops [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd12, 5'd13};

  task automatic scramble_issue();
    issue_op  = 5'($urandom);
    issue_rs1 = $urandom;
    issue_rs2 = $urandom;
    issue_imm = $urandom;
    issue_rd  = 5'($urandom);
    issue_use_imm = 1'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; issue_valid = 1'b0; wb_ready = 1'b0;
    scramble_issue();
    repeat (2) @(posedge soc_clk);
    @(negedge soc_clk);
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    n_vec++; if ({dat_ready, wb_valid} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got dat_ready=%b wb_valid=%b want 0", dat_ready, wb_valid); end
    n_vec++; if ({ALU_dat1, ALU_dat2, wb_data} !== 96'd0) begin n_err++; $display("FAIL reset_data: got dat1=%h dat2=%h wb_data=%h want 0", ALU_dat1, ALU_dat2, wb_data); end
    n_vec++; if ({Instruction_to_ALU, wb_rd} !== 10'd0) begin n_err++; $display("FAIL reset_op_rd: got op=%h rd=%h want 0", Instruction_to_ALU, wb_rd); end
    reset_n = 1'b1;
    @(posedge soc_clk); #1;
  endtask

  // One op through the full latency with wb_ready high; starts and ends in IDLE.
  task automatic test_single_op(input string tag, input logic [4:0] op, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm, input logic use_imm,
                                input logic [4:0] rd);
    logic [31:0] src2, exp2, expr;
    src2 = use_imm ? imm : rs2;
    exp2 = ref_dat2(op, src2);
    expr = ref_alu(op, rs1, src2);
    issue_op = op; issue_rs1 = rs1; issue_rs2 = rs2; issue_imm = imm;
    issue_use_imm = use_imm; issue_rd = rd; issue_valid = 1'b1; wb_ready = 1'b1;
    @(negedge soc_clk);
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL %s_issue_ready: got %b want 1", tag, issue_ready); end
    @(posedge soc_clk); #1;
    issue_valid = 1'b0;
    scramble_issue();
    @(negedge soc_clk);
    n_vec++; if (dat_ready !== 1'b1) begin n_err++; $display("FAIL %s_dat_ready: got %b want 1", tag, dat_ready); end
    n_vec++; if (ALU_dat1 !== rs1) begin n_err++; $display("FAIL %s_dat1: got %h want %h", tag, ALU_dat1, rs1); end
    n_vec++; if (ALU_dat2 !== exp2) begin n_err++; $display("FAIL %s_dat2: got %h want %h", tag, ALU_dat2, exp2); end
    n_vec++; if (Instruction_to_ALU !== op) begin n_err++; $display("FAIL %s_op: got %h want %h", tag, Instruction_to_ALU, op); end
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL %s_busy: got issue_ready=%b want 0", tag, issue_ready); end
    @(negedge soc_clk);
    n_vec++; if ({dat_ready, wb_valid} !== 2'b00) begin n_err++; $display("FAIL %s_capture: got dat_ready=%b wb_valid=%b want 0", tag, dat_ready, wb_valid); end
    @(negedge soc_clk);
    n_vec++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL %s_wb_valid: got %b want 1", tag, wb_valid); end
    n_vec++; if (wb_data !== expr) begin n_err++; $display("FAIL %s_wb_data: got %h want %h", tag, wb_data, expr); end
    n_vec++; if (wb_rd !== rd) begin n_err++; $display("FAIL %s_wb_rd: got %h want %h", tag, wb_rd, rd); end
    @(posedge soc_clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(0, 4095)) - 2048) : $urandom;
      test_single_op("rand", legal_ops[$urandom_range(0, 9)], $urandom, $urandom, imm,
                     1'($urandom), 5'($urandom));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a, exp_b;
    logic        stable_ok;
    exp_a = ref_alu(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F);
    exp_b = ref_alu(OP_SRL, 32'h8000_0000, 32'h0000_0024);
    issue_op = OP_XOR; issue_rs1 = 32'h1234_5678; issue_rs2 = 32'h0F0F_0F0F;
    issue_use_imm = 1'b0; issue_rd = 5'd17; issue_valid = 1'b1; wb_ready = 1'b0;
    @(posedge soc_clk); #1;
    // A second op stays presented throughout; it must not be taken early.
    issue_op = OP_SRL; issue_rs1 = 32'h8000_0000; issue_rs2 = 32'h0000_0024; issue_rd = 5'd9;
    repeat (2) @(posedge soc_clk);
    stable_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge soc_clk);
      if (!(wb_valid === 1'b1 && wb_data === exp_a && wb_rd === 5'd17 && issue_ready === 1'b0 && dat_ready === 1'b0)) begin
        stable_ok = 1'b0;
        $display("FAIL bp_hold_c%0d: got valid=%b data=%h rd=%h issue_ready=%b want 1 %h 11 0", c, wb_valid, wb_data, wb_rd, issue_ready, exp_a);
      end
      @(posedge soc_clk);
    end
    n_vec++; if (!stable_ok) n_err++;
    #1 wb_ready = 1'b1;
    @(negedge soc_clk);
    n_vec++; if ({wb_valid, issue_ready} !== 2'b11) begin n_err++; $display("FAIL bp_release: got wb_valid=%b issue_ready=%b want 11", wb_valid, issue_ready); end
    @(posedge soc_clk); #1;
    issue_valid = 1'b0;
    @(negedge soc_clk);
    n_vec++; if ({dat_ready, wb_valid} !== 2'b10) begin n_err++; $display("FAIL bp_next_issue: got dat_ready=%b wb_valid=%b want 10", dat_ready, wb_valid); end
    n_vec++; if (ALU_dat2 !== 32'd4) begin n_err++; $display("FAIL bp_next_dat2: got %h want 4", ALU_dat2); end
    repeat (2) @(negedge soc_clk);
    n_vec++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, exp_b, 5'd9}) begin n_err++; $display("FAIL bp_next_wb: got valid=%b data=%h rd=%h want 1 %h 09", wb_valid, wb_data, wb_rd, exp_b); end
    @(posedge soc_clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops [3];
    logic [31:0] a [3], b [3], exp_d [3];
    logic [4:0]  rds [3];
    int idx_in, idx_out, last_cyc;
    logic acc;
    for (int k = 0; k < 3; k++) begin
      ops[k] = legal_ops[$urandom_range(0, 9)];
      a[k] = $urandom; b[k] = $urandom; rds[k] = 5'(k * 7 + 3);
      exp_d[k] = ref_alu(ops[k], a[k], b[k]);
    end
    idx_in = 0; idx_out = 0; last_cyc = 0;
    wb_ready = 1'b1; issue_use_imm = 1'b0;
    issue_op = ops[0]; issue_rs1 = a[0]; issue_rs2 = b[0]; issue_rd = rds[0]; issue_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && idx_out < 3; cyc++) begin
      @(negedge soc_clk);
      if (wb_valid === 1'b1) begin
        n_vec++; if ({wb_rd, wb_data} !== {rds[idx_out], exp_d[idx_out]}) begin n_err++; $display("FAIL b2b_wb%0d: got rd=%h data=%h want %h %h", idx_out, wb_rd, wb_data, rds[idx_out], exp_d[idx_out]); end
        if (idx_out > 0) begin
          n_vec++; if (cyc - last_cyc != 3) begin n_err++; $display("FAIL b2b_spacing%0d: got %0d cycles want 3", idx_out, cyc - last_cyc); end
        end
        last_cyc = cyc;
        idx_out++;
      end
      acc = issue_valid && issue_ready;
      @(posedge soc_clk); #1;
      if (acc) begin
        idx_in++;
        if (idx_in < 3) begin
          issue_op = ops[idx_in]; issue_rs1 = a[idx_in]; issue_rs2 = b[idx_in]; issue_rd = rds[idx_in];
        end else issue_valid = 1'b0;
      end
    end
    n_vec++; if (idx_out != 3) begin n_err++; $display("FAIL b2b_count: got %0d results want 3", idx_out); end
    issue_valid = 1'b0;
    repeat (2) @(posedge soc_clk); #1;
  endtask

  task automatic test_reset_mid();
    logic saw_valid;
    issue_op = OP_ADD; issue_rs1 = 32'h1111_1111; issue_rs2 = 32'h2222_2222;
    issue_use_imm = 1'b0; issue_rd = 5'd30; issue_valid = 1'b1; wb_ready = 1'b1;
    @(posedge soc_clk); #1;
    issue_valid = 1'b0;
    @(posedge soc_clk); #1;
    reset_n = 1'b0;
    @(posedge soc_clk);
    @(negedge soc_clk);
    n_vec++; if ({dat_ready, wb_valid, issue_ready} !== 3'b001) begin n_err++; $display("FAIL rstmid_ctrl: got dat_ready=%b wb_valid=%b issue_ready=%b want 001", dat_ready, wb_valid, issue_ready); end
    n_vec++; if ({ALU_dat1, ALU_dat2, wb_data, Instruction_to_ALU, wb_rd} !== 106'd0) begin n_err++; $display("FAIL rstmid_data: got dat1=%h dat2=%h wb=%h op=%h rd=%h want 0", ALU_dat1, ALU_dat2, wb_data, Instruction_to_ALU, wb_rd); end
    reset_n = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge soc_clk);
      if (wb_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_vec++; if (saw_valid) begin n_err++; $display("FAIL rstmid_no_wb: got wb_valid=1 after reset want 0"); end
    @(posedge soc_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op("sll",   OP_SLL, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0000, 1'b0, 5'd5);
    test_single_op("srai",  OP_SRA, 32'h8000_0000, 32'h5555_5555, 32'h0000_0403, 1'b1, 5'd6);
    test_single_op("addi",  OP_ADD, 32'h0000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 5'd7);
    test_single_op("srl_big", OP_SRL, 32'hF000_0000, 32'h0000_0FFF, 32'h0, 1'b0, 5'd31);
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
